// File: rtl/complementador_a_2_serial_pkg.sv
// Shared types and constants for the bit-serial two's-complement unit.
package complementador_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam int N_DEF = 4;

   // Reference two's complement of the low n bits of a, i.e. (2^n - a) mod 2^n.
   function automatic logic [63:0] comp2_ref(input logic [63:0] a, input int unsigned n);
      logic [63:0] mask;
      mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
      return (64'd0 - a) & mask;
   endfunction

endpackage

// File: rtl/complementador_a_2_serial_if.sv
// Request/result bundle between a producer and the serial complementer.
interface complementador_a_2_serial_if
   import complementador_pkg::*;
#(
   parameter int N = N_DEF
);
   logic         start;
   logic [N-1:0] ABCD;
   logic [N-1:0] wxyz;
   logic         busy;
   logic         done;
   logic         sout;
   logic         sout_valid;

   modport master (
      output start, ABCD,
      input  wxyz, busy, done, sout, sout_valid
   );

   modport slave (
      input  start, ABCD,
      output wxyz, busy, done, sout, sout_valid
   );
endinterface

// File: rtl/complementador_a_2_serial_celda.sv
// One-bit Mealy cell: passes bits through until the first 1 has gone by,
// then inverts every following bit.
module complementador_celda_serial
   import complementador_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic b,
   output logic r,
   output logic found
);
   logic found_q;

   // Remember whether a 1 has already been consumed in this operand.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         found_q <= 1'b0;
      end else if (en) begin
         found_q <= found_q | b;
      end
   end

   assign r     = found_q ? ~b : b;
   assign found = found_q;
endmodule

// File: rtl/complementador_a_2_serial.sv
// Bit-serial two's complementer: captures an N-bit word, walks it LSB first
// through the Mealy cell and publishes the assembled result with a done pulse.
module complementador_a_2_serial
   import complementador_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   complementador_a_2_serial_if.slave  bus
);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_t           state_q;
   logic [N-1:0]     sreg_q;
   // Only the upper N-1 result bits need storage: the last bit is merged in
   // on the same edge that loads wxyz.
   logic [N-1:1]     res_q;
   logic [N-1:0]     res_d;
   logic [CNT_W-1:0] cnt_q;
   logic [N-1:0]     wxyz_q;
   logic             busy_q;
   logic             done_q;
   logic             sout_valid_q;

   logic             accept;
   logic             shift_en;
   logic             r;
   logic             found_unused;

   assign accept   = (state_q == IDLE) && bus.start;
   assign shift_en = (state_q == SHIFT);
   assign res_d    = {r, res_q};

   complementador_celda_serial u_celda (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .en    (shift_en),
      .b     (sreg_q[0]),
      .r     (r),
      .found (found_unused)
   );

   // Sequencer: IDLE -> SHIFT (N cycles) -> DONE (1 cycle) -> IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sreg_q       <= '0;
         res_q        <= '0;
         cnt_q        <= '0;
         wxyz_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sout_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  sreg_q       <= bus.ABCD;
                  res_q        <= '0;
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
                  sout_valid_q <= 1'b1;
                  state_q      <= SHIFT;
               end
            end
            SHIFT: begin
               sreg_q <= sreg_q >> 1;
               res_q  <= res_d[N-1:1];
               if (cnt_q == CNT_W'(N - 1)) begin
                  wxyz_q       <= res_d;
                  done_q       <= 1'b1;
                  sout_valid_q <= 1'b0;
                  state_q      <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.wxyz       = wxyz_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.sout_valid = sout_valid_q;
   assign bus.sout       = sout_valid_q & r;
endmodule

// File: tb/tb_complementador_a_2_serial.sv
// Self-checking bench for the bit-serial two's complementer (N=4 and N=8).
module tb_complementador_a_2_serial;
   import complementador_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   complementador_a_2_serial_if #(.N(4)) bus4 ();
   complementador_a_2_serial_if #(.N(8)) bus8 ();

   complementador_a_2_serial #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   complementador_a_2_serial #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] abcd;
      logic [3:0] exp_wxyz;
      logic [3:0] exp_sout;   // stream bit i is expected at position i
   } vec_t;

   vec_t vecs [5];
   int   vals [46];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference: (2^n - a) mod 2^n.
   function automatic int model(input int a, input int n);
      return ((1 << n) - a) % (1 << n);
   endfunction

   // One complete N=4 operation from an idle unit, checking every cycle.
   task automatic run_op4(input logic [3:0] a, input logic [3:0] exp_w,
                          input logic [3:0] exp_s, input string tag);
      logic [3:0] got_s;
      got_s = '0;
      bus4.ABCD  = a;
      bus4.start = 1'b1;
      tick;
      bus4.start = 1'b0;
      bus4.ABCD  = ~a;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_busy_shift"}, bus4.busy, 1);
         check({tag, "_valid_shift"}, bus4.sout_valid, 1);
         check({tag, "_done_early"}, bus4.done, 0);
         got_s[i] = bus4.sout;
         tick;
      end
      check({tag, "_done"}, bus4.done, 1);
      check({tag, "_wxyz"}, bus4.wxyz, exp_w);
      check({tag, "_valid_done"}, bus4.sout_valid, 0);
      check({tag, "_busy_done"}, bus4.busy, 1);
      check({tag, "_sout_stream"}, got_s, exp_s);
      tick;
      check({tag, "_done_pulse"}, bus4.done, 0);
      check({tag, "_busy_idle"}, bus4.busy, 0);
      check({tag, "_wxyz_hold"}, bus4.wxyz, exp_w);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone, idx, last, nbits, lat, dcount;
      logic [3:0] sacc;
      logic [7:0] v8;

      vecs[0] = '{4'b0001, 4'b1111, 4'b1111};
      vecs[1] = '{4'b0110, 4'b1010, 4'b1010};
      vecs[2] = '{4'b0000, 4'b0000, 4'b0000};
      vecs[3] = '{4'b1000, 4'b1000, 4'b1000};
      vecs[4] = '{4'b1111, 4'b0001, 4'b0001};

      rst        = 1'b1;
      bus4.start = 1'b0;
      bus4.ABCD  = '0;
      bus8.start = 1'b0;
      bus8.ABCD  = '0;
      tick;
      tick;
      rst = 1'b0;

      // Reset state
      check("rst_state", dut4.state_q, IDLE);
      check("rst_wxyz", bus4.wxyz, 0);
      check("rst_busy", bus4.busy, 0);
      check("rst_done", bus4.done, 0);
      check("rst_sout", bus4.sout, 0);
      check("rst_sout_valid", bus4.sout_valid, 0);
      check("rst8_wxyz", bus8.wxyz, 0);
      check("rst8_busy", bus8.busy, 0);

      // Directed table
      for (int i = 0; i < 5; i++) begin
         run_op4(vecs[i].abcd, vecs[i].exp_wxyz, vecs[i].exp_sout, $sformatf("vec%0d", i));
      end

      // Back-to-back sweep plus random operands, start held high
      for (int i = 0; i < 16; i++) vals[i] = i;
      for (int i = 16; i < 46; i++) vals[i] = int'($urandom_range(0, 15));
      ndone = 0;
      last  = -1;
      nbits = 0;
      sacc  = '0;
      bus4.ABCD  = 4'(vals[0]);
      bus4.start = 1'b1;
      idx = 1;
      for (int cyc = 0; cyc < 600 && ndone < 46; cyc++) begin
         tick;
         if (bus4.sout_valid) begin
            if (nbits < 4) sacc[nbits] = bus4.sout;
            nbits++;
         end
         if (bus4.done) begin
            check("b2b_wxyz", bus4.wxyz, model(vals[ndone], 4));
            check("b2b_sout", sacc, model(vals[ndone], 4));
            check("b2b_nbits", nbits, 4);
            if (last >= 0) check("b2b_spacing", cyc - last, 6);
            last  = cyc;
            nbits = 0;
            ndone++;
            if (idx < 46) begin
               bus4.ABCD = 4'(vals[idx]);
               idx++;
            end else begin
               bus4.start = 1'b0;
            end
         end
      end
      check("b2b_count", ndone, 46);
      bus4.start = 1'b0;
      tick;
      tick;

      // Start requests during SHIFT and DONE are ignored
      bus4.ABCD  = 4'b0011;
      bus4.start = 1'b1;
      tick;
      bus4.start = 1'b0;
      bus4.ABCD  = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         check("ign_busy_shift", bus4.busy, 1);
         bus4.start = (i == 1);
         tick;
      end
      check("ign_done", bus4.done, 1);
      check("ign_wxyz", bus4.wxyz, 4'b1101);
      check("ign_busy_done", bus4.busy, 1);
      bus4.start = 1'b1;
      tick;
      bus4.start = 1'b0;
      check("ign_state_idle", dut4.state_q, IDLE);
      check("ign_busy_idle", bus4.busy, 0);
      tick;
      check("ign_no_accept", bus4.busy, 0);
      check("ign_wxyz_hold", bus4.wxyz, 4'b1101);

      // Reset in the third SHIFT cycle aborts the operation
      bus4.ABCD  = 4'b0101;
      bus4.start = 1'b1;
      tick;
      bus4.start = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("abort_state", dut4.state_q, IDLE);
      check("abort_wxyz", bus4.wxyz, 0);
      check("abort_busy", bus4.busy, 0);
      check("abort_done", bus4.done, 0);
      check("abort_valid", bus4.sout_valid, 0);
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (bus4.done) dcount++;
      end
      check("abort_no_done", dcount, 0);
      run_op4(4'b0101, 4'b1011, 4'b1011, "after_abort");

      // Reset wins over a simultaneous start
      bus4.ABCD  = 4'b0001;
      bus4.start = 1'b1;
      rst        = 1'b1;
      tick;
      rst        = 1'b0;
      bus4.start = 1'b0;
      check("rst_start_state", dut4.state_q, IDLE);
      check("rst_start_busy", bus4.busy, 0);
      tick;
      check("rst_start_busy2", bus4.busy, 0);

      // N=8: 0x01 first, then random operands
      for (int k = 0; k < 6; k++) begin
         v8 = (k == 0) ? 8'h01 : 8'($urandom_range(0, 255));
         bus8.ABCD  = v8;
         bus8.start = 1'b1;
         tick;
         bus8.start = 1'b0;
         bus8.ABCD  = ~v8;
         lat = 1;
         while (!bus8.done && lat < 40) begin
            tick;
            lat++;
         end
         check("n8_latency", lat, 9);
         check("n8_wxyz", bus8.wxyz, model(int'(v8), 8));
         tick;
         check("n8_busy_idle", bus8.busy, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
